// File: rtl/pht_update_scheduler_if.sv
// Update-request and table-write-port bundle for the PHT update scheduler.
//   reqValid/reqIndex/reqData : per-lane counter-update requests (producer -> scheduler)
//   reqReady                  : all lanes may be accepted this cycle (scheduler -> producer)
//   wrEn/wrIndex/wrData       : registered table write port (scheduler -> table)
// master = execution-lane/table side, slave = scheduler side.
interface pht_update_scheduler_if #(
    parameter int ENTRY_NUM = 256,
    parameter int DATA_W    = 16,
    parameter int REQ_NUM   = 2,
    localparam int INDEX_W  = $clog2(ENTRY_NUM)
);
    logic [REQ_NUM-1:0] reqValid;
    logic [INDEX_W-1:0] reqIndex [REQ_NUM];
    logic [DATA_W-1:0]  reqData  [REQ_NUM];
    logic               reqReady;
    logic               wrEn;
    logic [INDEX_W-1:0] wrIndex;
    logic [DATA_W-1:0]  wrData;

    modport master (
        output reqValid, reqIndex, reqData,
        input  reqReady, wrEn, wrIndex, wrData
    );

    modport slave (
        input  reqValid, reqIndex, reqData,
        output reqReady, wrEn, wrIndex, wrData
    );
endinterface

// File: rtl/pht_update_scheduler.sv
// Pattern-history-table update scheduler.
// Accepts up to REQ_NUM update requests per cycle, merges same-cycle index
// collisions (highest lane wins), queues survivors in a circular FIFO and
// drains one entry per cycle onto the table write port. In INIT it owns the
// write port and sweeps every entry to initValue.
// Ports:
//   clk, rst (async, active-low)
//   initStart     : pulse; flush queue and restart the sweep at index 0
//   initValue     : sweep write data, sampled every sweep cycle
//   lookupIndex   : fetch read index; lookupPending flags a queued match
//   initBusy      : sweep in progress; initDone pulses after the last sweep write
//   dropCount     : saturating count of requests lost to collisions
//   bus (slave)   : request lanes, reqReady and the write port
module pht_update_scheduler #(
    parameter int ENTRY_NUM  = 256,
    parameter int DATA_W     = 16,
    parameter int REQ_NUM    = 2,
    parameter int FIFO_DEPTH = 4,
    localparam int INDEX_W   = $clog2(ENTRY_NUM)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               initStart,
    input  logic [DATA_W-1:0]  initValue,
    input  logic [INDEX_W-1:0] lookupIndex,
    output logic               lookupPending,
    output logic               initBusy,
    output logic               initDone,
    output logic [7:0]         dropCount,
    pht_update_scheduler_if.slave bus
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam logic [CNT_W-1:0]   DEPTH_C = CNT_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0]   REQ_C   = CNT_W'(REQ_NUM);
    localparam logic [INDEX_W-1:0] LAST_C  = INDEX_W'(ENTRY_NUM - 1);

    typedef enum logic {INIT, RUN} state_e;

    function automatic logic [7:0] sat_add8(input logic [7:0] a, input logic [7:0] b);
        logic [8:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[8] ? 8'hFF : s[7:0];
    endfunction

    // control state (async reset)
    state_e             state_q, state_d;
    logic [INDEX_W-1:0] sweep_idx_q, sweep_idx_d;
    logic [PTR_W-1:0]   head_q, head_d;
    logic [PTR_W-1:0]   tail_q, tail_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [7:0]         drop_count_q, drop_count_d;
    logic               init_done_q, init_done_d;
    logic               wr_en_q, wr_en_d;

    // datapath state (no reset; qualified by count/wr_en)
    logic [INDEX_W-1:0] wr_index_q, wr_index_d;
    logic [DATA_W-1:0]  wr_data_q, wr_data_d;
    logic [INDEX_W-1:0] fifo_index_q [FIFO_DEPTH];
    logic [INDEX_W-1:0] fifo_index_d [FIFO_DEPTH];
    logic [DATA_W-1:0]  fifo_data_q  [FIFO_DEPTH];
    logic [DATA_W-1:0]  fifo_data_d  [FIFO_DEPTH];

    logic               req_ready;
    logic [REQ_NUM-1:0] keep;
    logic [CNT_W-1:0]   n_keep;
    logic [7:0]         n_drop;
    logic               deq;
    logic [PTR_W-1:0]   slot;

    // Readiness uses only the registered count, so a same-cycle dequeue never
    // opens space for this cycle's lanes.
    assign req_ready = (state_q == RUN) && ((DEPTH_C - count_q) >= REQ_C);

    // Collision merge: a lane survives unless a higher-numbered valid lane
    // targets the same index this cycle.
    always_comb begin
        keep   = bus.reqValid;
        n_keep = '0;
        n_drop = '0;
        for (int i = 0; i < REQ_NUM; i++) begin
            for (int j = i + 1; j < REQ_NUM; j++) begin
                if (bus.reqValid[i] && bus.reqValid[j] &&
                    (bus.reqIndex[i] == bus.reqIndex[j])) begin
                    keep[i] = 1'b0;
                end
            end
        end
        for (int i = 0; i < REQ_NUM; i++) begin
            if (keep[i]) begin
                n_keep = n_keep + 1'b1;
            end else if (bus.reqValid[i]) begin
                n_drop = n_drop + 1'b1;
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        sweep_idx_d  = sweep_idx_q;
        head_d       = head_q;
        tail_d       = tail_q;
        count_d      = count_q;
        drop_count_d = drop_count_q;
        init_done_d  = 1'b0;
        wr_en_d      = 1'b0;
        wr_index_d   = wr_index_q;
        wr_data_d    = wr_data_q;
        fifo_index_d = fifo_index_q;
        fifo_data_d  = fifo_data_q;
        deq          = 1'b0;
        slot         = tail_q;

        if (initStart) begin
            // Flush wins over any same-cycle dequeue or accept.
            state_d     = INIT;
            sweep_idx_d = '0;
            head_d      = '0;
            tail_d      = '0;
            count_d     = '0;
        end else if (state_q == INIT) begin
            sweep_idx_d = sweep_idx_q + 1'b1;
            if (sweep_idx_q == LAST_C) begin
                sweep_idx_d = '0;
                state_d     = RUN;
                init_done_d = 1'b1;
            end
        end else begin
            if (count_q != '0) begin
                deq        = 1'b1;
                wr_en_d    = 1'b1;
                wr_index_d = fifo_index_q[head_q];
                wr_data_d  = fifo_data_q[head_q];
                head_d     = head_q + 1'b1;
            end
            if (req_ready) begin
                // Survivors are packed into consecutive slots in lane order.
                for (int i = 0; i < REQ_NUM; i++) begin
                    if (keep[i]) begin
                        fifo_index_d[slot] = bus.reqIndex[i];
                        fifo_data_d[slot]  = bus.reqData[i];
                        slot               = slot + 1'b1;
                    end
                end
                tail_d       = slot;
                drop_count_d = sat_add8(drop_count_q, n_drop);
                count_d      = count_q - CNT_W'(deq) + n_keep;
            end else begin
                count_d = count_q - CNT_W'(deq);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= INIT;
            sweep_idx_q  <= '0;
            head_q       <= '0;
            tail_q       <= '0;
            count_q      <= '0;
            drop_count_q <= '0;
            init_done_q  <= 1'b0;
            wr_en_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            sweep_idx_q  <= sweep_idx_d;
            head_q       <= head_d;
            tail_q       <= tail_d;
            count_q      <= count_d;
            drop_count_q <= drop_count_d;
            init_done_q  <= init_done_d;
            wr_en_q      <= wr_en_d;
        end
    end

    always_ff @(posedge clk) begin
        wr_index_q   <= wr_index_d;
        wr_data_q    <= wr_data_d;
        fifo_index_q <= fifo_index_d;
        fifo_data_q  <= fifo_data_d;
    end

    // Occupied slots are the count_q entries starting at head; the entry
    // already on the write port is no longer in the queue.
    always_comb begin
        lookupPending = 1'b0;
        for (int k = 0; k < FIFO_DEPTH; k++) begin
            if ((CNT_W'(k) < count_q) &&
                (fifo_index_q[head_q + PTR_W'(k)] == lookupIndex)) begin
                lookupPending = 1'b1;
            end
        end
    end

    // During INIT the sweep drives the port directly from sweep_idx_q, so the
    // write of index 0 is already visible while reset is held.
    assign bus.reqReady = req_ready;
    assign bus.wrEn     = (state_q == INIT) ? 1'b1        : wr_en_q;
    assign bus.wrIndex  = (state_q == INIT) ? sweep_idx_q : wr_index_q;
    assign bus.wrData   = (state_q == INIT) ? initValue   : wr_data_q;
    assign initBusy     = (state_q == INIT);
    assign initDone     = init_done_q;
    assign dropCount    = drop_count_q;

endmodule

// File: tb/tb_pht_update_scheduler.sv
module tb_pht_update_scheduler;

    typedef struct packed {
        logic [7:0]  idx;
        logic [15:0] data;
    } wr_t;

    logic        clk;
    logic        rst;
    logic        initStart;
    logic [15:0] initValue;
    logic [7:0]  lookupIndex;
    logic        lookupPending;
    logic        initBusy;
    logic        initDone;
    logic [7:0]  dropCount;

    int   n_checks = 0;
    int   n_errors = 0;
    int   done_cnt = 0;
    int   exp_drop = 0;
    wr_t  sb[$];

    pht_update_scheduler_if #(.ENTRY_NUM(256), .DATA_W(16), .REQ_NUM(2)) bus ();

    pht_update_scheduler #(
        .ENTRY_NUM(256), .DATA_W(16), .REQ_NUM(2), .FIFO_DEPTH(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .initStart(initStart),
        .initValue(initValue),
        .lookupIndex(lookupIndex),
        .lookupPending(lookupPending),
        .initBusy(initBusy),
        .initDone(initDone),
        .dropCount(dropCount),
        .bus(bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Write-port monitor: every write must match the head of the scoreboard.
    always @(negedge clk) begin
        if (rst) begin
            if (initDone) done_cnt++;
            if (bus.wrEn) begin
                if (sb.size() == 0) begin
                    check_val("wr_sb_size", sb.size(), 1);
                end else begin
                    wr_t e;
                    e = sb.pop_front();
                    check_val("wr_idx", bus.wrIndex, e.idx);
                    check_val("wr_data", bus.wrData, e.data);
                end
            end
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic push_sweep(input logic [15:0] v);
        for (int i = 0; i < 256; i++) sb.push_back({i[7:0], v});
    endtask

    task automatic wait_init_done();
        bit seen;
        seen = 0;
        for (int c = 0; c < 400 && !seen; c++) begin
            @(negedge clk);
            if (initDone) begin
                seen = 1;
                check_val("rdy_at_done", bus.reqReady, 1);
                check_val("busy_at_done", initBusy, 0);
            end
        end
        check_val("init_done_seen", seen, 1);
        next_cycle();
        check_val("done_pulse_low", initDone, 0);
    endtask

    task automatic wait_drain();
        int c;
        c = 0;
        while (sb.size() != 0 && c < 60) begin
            next_cycle();
            c++;
        end
        next_cycle();
        next_cycle();
        check_val("drain_left", sb.size(), 0);
    endtask

    // Drive one request beat; hold until accepted. With model set, the expected
    // writes (after collision merge) go to the scoreboard at acceptance.
    task automatic send(input logic [1:0] vld, input logic [7:0] i0, input logic [15:0] d0,
                        input logic [7:0] i1, input logic [15:0] d1, input bit model,
                        output int stalls);
        int  guard;
        bit  coll;
        stalls = 0;
        guard  = 0;
        bus.reqValid    = vld;
        bus.reqIndex[0] = i0;
        bus.reqData[0]  = d0;
        bus.reqIndex[1] = i1;
        bus.reqData[1]  = d1;
        while (!bus.reqReady && guard < 50) begin
            next_cycle();
            stalls++;
            guard++;
        end
        if (!bus.reqReady) begin
            check_val("send_ready", bus.reqReady, 1);
        end else begin
            if (model) begin
                coll = vld[0] && vld[1] && (i0 == i1);
                if (vld[0] && !coll) sb.push_back({i0, d0});
                if (vld[1]) sb.push_back({i1, d1});
                if (coll && exp_drop < 255) exp_drop++;
            end
            next_cycle();
        end
        bus.reqValid = '0;
    endtask

    initial begin
        int s1, s2, s3;
        rst          = 1'b0;
        initStart    = 1'b0;
        initValue    = 16'hAAAA;
        lookupIndex  = 8'd5;
        bus.reqValid = '0;
        for (int i = 0; i < 2; i++) begin
            bus.reqIndex[i] = '0;
            bus.reqData[i]  = '0;
        end

        // Reset values
        #12;
        check_val("rst_wren", bus.wrEn, 1);
        check_val("rst_wridx", bus.wrIndex, 0);
        check_val("rst_wrdata", bus.wrData, 16'hAAAA);
        check_val("rst_ready", bus.reqReady, 0);
        check_val("rst_busy", initBusy, 1);
        check_val("rst_done", initDone, 0);
        check_val("rst_drop", dropCount, 0);
        check_val("rst_lookup", lookupPending, 0);

        // Reset sweep
        push_sweep(16'hAAAA);
        @(posedge clk);
        #1 rst = 1'b1;
        wait_init_done();
        check_val("sweep_left", sb.size(), 0);
        next_cycle();
        check_val("done_once", done_cnt, 1);

        // Single request: lane 0, index 5
        check_val("lkp_before", lookupPending, 0);
        send(2'b01, 8'd5, 16'h1234, 8'd0, 16'h0, 1, s1);
        @(negedge clk);
        check_val("lat_cyc1_wren", bus.wrEn, 0);
        check_val("lkp_queued", lookupPending, 1);
        @(negedge clk);
        check_val("lat_cyc2_wren", bus.wrEn, 1);
        check_val("lkp_on_port", lookupPending, 0);
        next_cycle();
        wait_drain();

        // Collision on index 9
        send(2'b11, 8'd9, 16'h1111, 8'd9, 16'h2222, 1, s1);
        wait_drain();
        check_val("coll_drop", dropCount, exp_drop);
        check_val("coll_drop_one", dropCount, 1);

        // Backpressure: three back-to-back two-lane beats
        send(2'b11, 8'd30, 16'h3030, 8'd31, 16'h3131, 1, s1);
        send(2'b11, 8'd32, 16'h3232, 8'd33, 16'h3333, 1, s2);
        send(2'b11, 8'd34, 16'h3434, 8'd35, 16'h3535, 1, s3);
        check_val("bp_no_stall", s1 + s2, 0);
        check_val("bp_stall", s3, 1);
        wait_drain();

        // initStart with three entries queued
        lookupIndex = 8'd22;
        sb.push_back({8'd20, 16'h2020});
        send(2'b11, 8'd20, 16'h2020, 8'd21, 16'h2121, 0, s1);
        send(2'b11, 8'd22, 16'h2222, 8'd23, 16'h2323, 0, s2);
        check_val("flush_lkp_before", lookupPending, 1);
        initValue = 16'h5555;
        push_sweep(16'h5555);
        initStart = 1'b1;
        next_cycle();
        initStart = 1'b0;
        check_val("flush_lkp_after", lookupPending, 0);
        check_val("flush_busy", initBusy, 1);
        done_cnt = 0;
        wait_init_done();
        check_val("resweep_left", sb.size(), 0);
        check_val("resweep_done_once", done_cnt, 1);

        // Saturation: 300 collisions
        for (int n = 0; n < 300; n++) begin
            send(2'b11, 8'd70, 16'h0700, 8'd70, n[15:0], 1, s1);
        end
        wait_drain();
        check_val("sat_drop_model", dropCount, exp_drop);
        check_val("sat_drop_255", dropCount, 255);

        // Asynchronous reset mid-operation
        lookupIndex = 8'd40;
        send(2'b11, 8'd40, 16'h4040, 8'd41, 16'h4141, 0, s1);
        check_val("pre_rst_lkp", lookupPending, 1);
        sb.delete();
        rst = 1'b0;
        #1;
        check_val("arst_wren", bus.wrEn, 1);
        check_val("arst_wridx", bus.wrIndex, 0);
        check_val("arst_wrdata", bus.wrData, 16'h5555);
        check_val("arst_drop", dropCount, 0);
        check_val("arst_busy", initBusy, 1);
        check_val("arst_ready", bus.reqReady, 0);
        check_val("arst_lkp", lookupPending, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/pht_update_scheduler.md
# pht_update_scheduler

Sequencer and write-port arbiter for the per-address pattern history table of the branch predictor. It accepts up to REQ_NUM counter-update requests per cycle from the integer execution lanes and merges same-index collisions. It queues the survivors and drains them through the table's single write port, one entry per cycle. After reset, or on request, it owns that write port to sweep every entry to a programmable initial value.

## Interface
- ENTRY_NUM, 256: number of table entries; INDEX_W = $clog2(ENTRY_NUM).
- DATA_W, 16: entry width, e.g. packed 2-bit counters.
- REQ_NUM, 2: request lanes per cycle.
- FIFO_DEPTH, 4: queue depth; must be >= REQ_NUM and a power of two.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous reset, active-low.
- initStart  in  1  one-cycle pulse that discards the queue and starts a new sweep.
- initValue  in  DATA_W  value written by the sweep; sampled every sweep cycle.
- reqValid[REQ_NUM]  in  1 each  update request valid.
- reqIndex[REQ_NUM]  in  INDEX_W each  target entry.
- reqData[REQ_NUM]  in  DATA_W each  new entry value.
- reqReady  out  1  all lanes may be accepted this cycle.
- lookupIndex  in  INDEX_W  index being read by fetch.
- lookupPending  out  1  combinational; a queued, not yet written entry matches lookupIndex.
- wrEn  out  1  table write enable, registered.
- wrIndex  out  INDEX_W  table write address, registered.
- wrData  out  DATA_W  table write data, registered.
- initBusy  out  1  high while the sweep is in progress.
- initDone  out  1  one-cycle pulse after the last sweep write.
- dropCount  out  8  saturating count of requests lost to collisions.

## Operation
- States: INIT and RUN.
- Reset puts the block in INIT with sweepIdx = 0, the queue empty and dropCount = 0.
- INIT, each cycle:
  - wrEn = 1, wrIndex = sweepIdx, wrData = initValue.
  - sweepIdx increments.
  - After writing index ENTRY_NUM-1, the block moves to RUN and pulses initDone.
  - reqReady = 0; requests are ignored.
- initStart in RUN or INIT:
  - Next state is INIT with sweepIdx = 0.
  - The queue is flushed and its entries are never written.
  - Mid-sweep, the sweep restarts at index 0.
- RUN accept rule: reqReady = (FIFO_DEPTH - count) >= REQ_NUM, using the registered count. A dequeue in the same cycle does not raise reqReady.
  - When reqReady = 1, every valid lane is accepted that cycle.
  - When reqReady = 0, valid lanes are ignored; the producer holds them.
- Collision merge: two accepted valid lanes with equal reqIndex in the same cycle keep only the higher-numbered lane. Each discarded lane adds 1 to dropCount, saturating at 255.
- Enqueue order is ascending lane number. The queue is a circular buffer with wrap-around head and tail pointers and a count of width $clog2(FIFO_DEPTH+1).
- Drain: in RUN with a non-empty queue, the head entry is dequeued and presented on wr* in the next cycle. Otherwise wrEn = 0.
- lookupPending compares lookupIndex against every occupied queue slot. It does not include the entry currently on wr*, which is already being written.
- No other merging is performed. Queued entries with equal indices are written in order; the last one wins.

## Timing
- Reset values: wrEn = 1, wrIndex = 0, wrData = initValue (INIT begins immediately), reqReady = 0, initBusy = 1, initDone = 0, dropCount = 0, lookupPending = 0.
- Sweep length: ENTRY_NUM cycles.
  - The first cycle after reset release writes index 0.
  - initDone is high in the cycle after index ENTRY_NUM-1 is written.
  - initBusy falls and reqReady may rise in that same cycle.
- Write latency: a request accepted at edge N, into an empty queue, appears on wr* in the cycle after edge N+1.
  - For two accepted lanes, lane 0 is written one cycle before lane 1.
- Throughput: one write per cycle; the sustained accept rate is 1 request per cycle.
- Reset assertion mid-operation clears the queue, dropCount and sweepIdx asynchronously. Outputs take their reset values immediately.

## Test plan
- Reset sweep, with ENTRY_NUM = 256 and initValue = 16'hAAAA, release rst:
  - Expect 256 consecutive writes, indices 0..255, all with data AAAA.
  - initDone pulses once and reqReady rises with it.
- Single request, in RUN with an empty queue, lane 0 index 5 data 0x1234:
  - Expect wrEn with 5/0x1234 exactly two cycles after acceptance.
  - lookupIndex = 5 gives lookupPending = 1 for exactly one cycle.
- Collision: lanes 0 and 1 both index 9, data 0x1111 and 0x2222:
  - Expect a single write of 9/0x2222 and dropCount = 1.
- Backpressure, FIFO_DEPTH = 4, both lanes driven for 3 cycles with distinct indices:
  - reqReady falls when count > 2; no lane is lost.
  - Writes occur in lane order at one per cycle.
- initStart with 3 entries queued:
  - The queued entries are never written; the sweep restarts at 0.
- Saturation: force 300 collisions.
  - dropCount holds at 255.
